fifo_wr_ctrl: RTL

- Write-side producer stage that sits directly upstream of the ip_fifo FIFO IP instance in the FIFO loopback design.
- Detects when the FIFO drains to almost-empty, waits a settle delay, then bursts an incrementing data pattern into the FIFO until almost-full.
- A read-side controller drains the FIFO downstream; this block only owns the write port.

---
 rtl/fifo_wr_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side producer for the loopback FIFO: on an almost-empty rising edge it waits
// DELAY_CYC cycles, then bursts an incrementing pattern until almost-full. Option: FIFO_WR_BURST_CNT_EN.
module fifo_wr_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DELAY_CYC = 10,
   parameter int unsigned DATA_MAX  = 254
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              almost_empty,
   input  logic              almost_full,
   input  logic              full,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   output logic              busy,
`ifdef FIFO_WR_BURST_CNT_EN
   output logic [15:0]       burst_cnt,
`endif
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic                ae_d1_q, ae_d2_q;
   logic                start;

   // Handshake: fifo_wr_en is valid, ~full is ready; a word transfers only when both are high,
   // otherwise fifo_wr_data holds.
   always_comb begin
      start   = ae_d1_q & ~ae_d2_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en_d = wr_en_q;
      data_d  = data_q;

      if (wr_en_q && !full) begin
         data_d = (data_q == DATA_W'(DATA_MAX)) ? '0 : data_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            wr_en_d = 1'b0;
            if (start) begin
               state_d = DELAY;
               cnt_d   = 8'd0;
            end
         end
         DELAY: begin
            wr_en_d = 1'b0;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'(DELAY_CYC - 1)) begin
               state_d = WRITE;
               wr_en_d = 1'b1;
            end
         end
         WRITE: begin
            // almost_full still leaves one free entry, so the current word is allowed through.
            if (almost_full) begin
               wr_en_d = 1'b0;
               state_d = IDLE;
            end else begin
               wr_en_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            wr_en_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         ae_d1_q <= 1'b0;
         ae_d2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_en_q <= wr_en_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         ae_d1_q <= almost_empty;
         ae_d2_q <= ae_d1_q;
      end
   end

`ifdef FIFO_WR_BURST_CNT_EN
   logic [15:0] burst_q, burst_d;

   always_comb begin
      burst_d = burst_q;
      if ((state_q == WRITE) && almost_full && (burst_q != 16'hFFFF)) begin
         burst_d = burst_q + 16'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         burst_q <= 16'd0;
      end else begin
         burst_q <= burst_d;
      end
   end

   assign burst_cnt = burst_q;
`endif

   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = data_q;
   assign busy         = busy_q;
   assign dbg_state_o  = state_q;

endmodule
